mul_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit for the MIPS32 datapath: the sequential companion to the combinational ALU, executing MULT, MULTU, DIV and DIVU into HI/LO result registers. It latches its operands on a start handshake and computes one bit per clock using shift-add multiplication or restoring division. It holds the 64-bit result until the next operation completes. The control unit stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/mul_div_unit.sv | 199 +++++++++++++++++++
 tb/tb_mul_div_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit (MULTU, MULT, DIVU, DIV) with HI/LO results.
//
// Operands are latched on an accepted start. The unit then does one shift-add multiply step
// or one restoring-divide step per clock for BUS_SIZE clocks, applies a one-cycle sign
// fix-up, and finally writes hi/lo/flagDivZero.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   start        request a new operation (sampled only in IDLE)
//   selector     00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   A, B         multiplicand/dividend and multiplier/divisor
//   busy         high while an operation is computing
//   done         one-cycle pulse when hi/lo/flagDivZero update
//   hi, lo       upper product word / remainder, lower product word / quotient
//   flagDivZero  last completed divide had B = 0; cleared by any completed multiply
module mul_div_unit #(
    parameter int unsigned BUS_SIZE = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          selector,
    input  logic [BUS_SIZE-1:0] A,
    input  logic [BUS_SIZE-1:0] B,
    output logic                busy,
    output logic                done,
    output logic [BUS_SIZE-1:0] hi,
    output logic [BUS_SIZE-1:0] lo,
    output logic                flagDivZero
);

    localparam int unsigned W  = BUS_SIZE;
    localparam int unsigned CW = $clog2(W) + 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   a_raw_q, a_raw_d;   // original A, returned as hi on divide-by-zero
    logic [W-1:0]   opnd_q, opnd_d;     // |multiplicand| or |divisor|
    logic [2*W-1:0] acc_q, acc_d;       // multiply: {upper, multiplier}; divide: {rem, quot}
    logic           sign_a_q, sign_a_d;
    logic           sign_x_q, sign_x_d;
    logic           divz_q, divz_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           fdz_q, fdz_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // Operand conditioning at accept time
    logic         is_signed;
    logic         a_neg, b_neg;
    logic [W-1:0] a_abs, b_abs;

    assign is_signed = selector[0];
    assign a_neg     = is_signed & A[W-1];
    assign b_neg     = is_signed & B[W-1];
    assign a_abs     = a_neg ? (~A + W'(1)) : A;
    assign b_abs     = b_neg ? (~B + W'(1)) : B;

    // One shift-add multiply step; the carry out of the add becomes the new top bit
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_next;

    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
    assign mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};

    // One restoring-divide step: shifted remainder needs W+1 bits, diff MSB is the borrow
    logic [W:0]     div_sr;
    logic [W+1:0]   div_diff;
    logic [2*W-1:0] div_next;

    assign div_sr   = acc_q[2*W-1:W-1];
    assign div_diff = {1'b0, div_sr} - {2'b0, opnd_q};
    assign div_next = div_diff[W+1] ? {div_sr[W-1:0], acc_q[W-2:0], 1'b0}
                                    : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};

    // Sign fix-up candidates
    logic [2*W-1:0] prod_neg;
    logic [W-1:0]   quot_fix, rem_fix;

    assign prod_neg = ~acc_q + (2*W)'(1);
    assign quot_fix = sign_x_q ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
    assign rem_fix  = sign_a_q ? (~acc_q[2*W-1:W] + W'(1)) : acc_q[2*W-1:W];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_raw_d  = a_raw_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        sign_a_d = sign_a_q;
        sign_x_d = sign_x_q;
        divz_d   = divz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        fdz_d    = fdz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StCalc;
                    cnt_d    = '0;
                    op_d     = selector;
                    a_raw_d  = A;
                    sign_a_d = a_neg;
                    sign_x_d = a_neg ^ b_neg;
                    divz_d   = (B == '0);
                    if (selector[1]) begin
                        opnd_d = b_abs;
                        acc_d  = {{W{1'b0}}, a_abs};
                    end else begin
                        opnd_d = a_abs;
                        acc_d  = {{W{1'b0}}, b_abs};
                    end
                end
            end
            StCalc: begin
                acc_d = op_q[1] ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StDone;
                if (op_q[1]) begin
                    if (divz_q) begin
                        acc_d = {a_raw_q, {W{1'b1}}};
                    end else if (op_q[0]) begin
                        acc_d = {rem_fix, quot_fix};
                    end
                end else if (op_q[0] && sign_x_q) begin
                    acc_d = prod_neg;
                end
            end
            StDone: begin
                state_d = StIdle;
                hi_d    = acc_q[2*W-1:W];
                lo_d    = acc_q[W-1:0];
                fdz_d   = op_q[1] & divz_q;
            end
            default: state_d = StIdle;
        endcase
    end

    // busy/done are registered from the current state, so they trail it by one edge:
    // busy covers the 33 edges after acceptance and done rises with the hi/lo update.
    assign busy_d = (state_q == StCalc) || (state_q == StFix);
    assign done_d = (state_q == StDone);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            a_raw_q  <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            sign_a_q <= 1'b0;
            sign_x_q <= 1'b0;
            divz_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            fdz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_raw_q  <= a_raw_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            sign_a_q <= sign_a_d;
            sign_x_q <= sign_x_d;
            divz_q   <= divz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            fdz_q    <= fdz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign flagDivZero = fdz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed vector table, randomized ops against a reference
// model, and hand-written sequences for ignored start and mid-operation reset.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  selector;
    logic [31:0] A, B;
    logic        busy, done;
    logic [31:0] hi, lo;
    logic        flagDivZero;

    int tests;
    int fails;

    mul_div_unit #(.BUS_SIZE(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .selector   (selector),
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .flagDivZero(flagDivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        fdz;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit / signed integer arithmetic. Returns {fdz, hi, lo}.
    function automatic logic [64:0] model(input logic [1:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        longint      sp;
        int          sa, sb, q, r;
        case (sel)
            2'd0: begin
                p = {32'b0, a} * {32'b0, b};
                return {1'b0, p};
            end
            2'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return {1'b0, sp};
            end
            2'd2: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return {1'b0, 32'h0, 32'h8000_0000};
                sa = a;
                sb = b;
                q  = sa / sb;
                r  = sa % sb;
                return {1'b0, r, q};
            end
        endcase
    endfunction

    // Issue one op, wait (bounded) for done, check latency, busy length and results.
    task automatic do_op(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic efdz,
                         input string tag);
        int lat;
        int bcnt;
        @(negedge clk);
        start    = 1'b1;
        selector = sel;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        A        = $urandom;
        B        = $urandom;
        selector = 2'($urandom);
        lat  = 0;
        bcnt = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
        end
        chk({tag, " latency"}, 64'(lat), 64'd34);
        chk({tag, " busy cycles"}, 64'(bcnt), 64'd33);
        chk({tag, " hi"}, 64'(hi), 64'(ehi));
        chk({tag, " lo"}, 64'(lo), 64'(elo));
        chk({tag, " flagDivZero"}, 64'(flagDivZero), 64'(efdz));
        @(posedge clk);
        #1;
        chk({tag, " done single pulse"}, 64'(done), 64'd0);
    endtask

    logic [64:0] m;
    logic [1:0]  rs;
    logic [31:0] ra, rb;
    int          lat, dcnt, bcnt;

    initial begin
        tests    = 0;
        fails    = 0;
        reset    = 1'b1;
        start    = 1'b0;
        selector = 2'd0;
        A        = '0;
        B        = '0;

        vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'd2,          32'h1,         32'hFFFF_FFFE, 1'b0};
        vecs[1] = '{2'd1, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2] = '{2'd2, 32'd100,       32'd7,          32'd2,         32'd14,        1'b0};
        vecs[3] = '{2'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0};
        vecs[5] = '{2'd3, 32'd10,        32'd0,          32'd10,        32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{2'd0, 32'd3,         32'd4,          32'd0,         32'd12,        1'b0};
        vecs[7] = '{2'd2, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF, 1'b1};
        vecs[8] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         1'b0};
        vecs[9] = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        chk("reset flagDivZero", 64'(flagDivZero), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].fdz,
                  $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            rs = 2'($urandom);
            ra = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            m = model(rs, ra, rb);
            do_op(rs, ra, rb, m[63:32], m[31:0], m[64], $sformatf("rnd%0d", i));
        end

        // Stray start during CALC must be ignored
        @(negedge clk);
        start    = 1'b1;
        selector = 2'd0;
        A        = 32'd6;
        B        = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        dcnt  = 0;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dcnt++;
                if (lat == 0) lat = n;
            end
            if (n == 4) begin
                start    = 1'b1;
                selector = 2'd2;
                A        = 32'd1;
                B        = 32'd1;
            end
            if (n == 5) start = 1'b0;
        end
        chk("ignore latency", 64'(lat), 64'd34);
        chk("ignore done count", 64'(dcnt), 64'd1);
        chk("ignore lo", 64'(lo), 64'd42);
        chk("ignore hi", 64'(hi), 64'd0);

        // Reset at CALC iteration 10 discards the operation
        @(negedge clk);
        start    = 1'b1;
        selector = 2'd2;
        A        = 32'd100;
        B        = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
        end
        chk("pre-reset busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midreset busy", 64'(busy), 64'd0);
        chk("midreset hi", 64'(hi), 64'd0);
        chk("midreset lo", 64'(lo), 64'd0);
        chk("midreset done", 64'(done), 64'd0);
        dcnt = 0;
        bcnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
            if (busy) bcnt++;
        end
        chk("midreset no done", 64'(dcnt), 64'd0);
        chk("midreset stays idle", 64'(bcnt), 64'd0);
        do_op(2'd2, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, "after reset");

        // Reset coincident with start wins
        @(negedge clk);
        start    = 1'b1;
        reset    = 1'b1;
        selector = 2'd0;
        A        = 32'd5;
        B        = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b0;
        bcnt  = 0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            #1;
            if (busy) bcnt++;
        end
        chk("reset+start no busy", 64'(bcnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
